// File: rtl/seg7_frame_decoder_if.sv
// seg7_frame_decoder_if: segment-sample input and message-frame output bundle
// for seg7_frame_decoder (rev 1.0).
`default_nettype none

interface seg7_frame_decoder_if #(
  parameter int NUM_DIGITS = 5
);
  logic [6:0]              seg_in;
  logic [2:0]              digit_sel;
  logic                    seg_strobe;
  logic [8*NUM_DIGITS-1:0] msg_out;
  logic                    msg_valid;
  logic                    msg_ready;
  logic                    decode_err;
  logic                    overrun;

  modport master (
    output seg_in, digit_sel, seg_strobe, msg_ready,
    input  msg_out, msg_valid, decode_err, overrun
  );

  modport slave (
    input  seg_in, digit_sel, seg_strobe, msg_ready,
    output msg_out, msg_valid, decode_err, overrun
  );
endinterface

`default_nettype wire

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: decodes multiplexed 7-segment samples into an ASCII frame
// with valid/ready output; optional glitch filter via SEG7_GLITCH_FILTER_EN (rev 1.0).
`default_nettype none

module seg7_frame_decoder #(
  parameter int NUM_DIGITS     = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STABLE_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  seg7_frame_decoder_if.slave bus
);

  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] expected;
  logic [7:0] slot [NUM_DIGITS];
  logic       valid;
  logic       derr;
  logic       ovr;

  logic [6:0] pattern;
  logic [8:0] decoded;
  logic       stable;
  logic       frame_hit;
  logic       write_en;

  // Result is {unknown_pattern, ascii}.
  function automatic logic [8:0] decode_seg(input logic [6:0] p);
    logic [8:0] r;
    r = 9'h13F;
    case (p)
      7'h3F: r = 9'h030;
      7'h06: r = 9'h031;
      7'h5B: r = 9'h032;
      7'h4F: r = 9'h033;
      7'h66: r = 9'h034;
      7'h6D: r = 9'h035;
      7'h7D: r = 9'h036;
      7'h07: r = 9'h037;
      7'h7F: r = 9'h038;
      7'h6F: r = 9'h039;
      7'h77: r = 9'h041;
      7'h7C: r = 9'h062;
      7'h39: r = 9'h043;
      7'h5E: r = 9'h064;
      7'h79: r = 9'h045;
      7'h71: r = 9'h046;
      7'h76: r = 9'h048;
      7'h1E: r = 9'h04A;
      7'h38: r = 9'h04C;
      7'h5C: r = 9'h06F;
      7'h73: r = 9'h050;
      7'h3E: r = 9'h055;
      7'h00: r = 9'h020;
      default: r = 9'h13F;
    endcase
    return r;
  endfunction

  assign pattern = SEG_ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
  assign decoded = decode_seg(pattern);

`ifdef SEG7_GLITCH_FILTER_EN
  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  logic [6:0]    prev_seg;
  logic [CW-1:0] same_cnt;

  // same_cnt counts consecutive past cycles whose sample matched its predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg <= '0;
      same_cnt <= '0;
    end else begin
      prev_seg <= bus.seg_in;
      if (bus.seg_in == prev_seg) begin
        if (same_cnt != CW'(STABLE_CYCLES)) same_cnt <= same_cnt + 1'b1;
      end else begin
        same_cnt <= '0;
      end
    end
  end

  if (STABLE_CYCLES <= 1) begin : g_no_hold
    assign stable = 1'b1;
  end else begin : g_hold
    assign stable = (bus.seg_in == prev_seg) && (same_cnt >= CW'(STABLE_CYCLES - 2));
  end
`else
  assign stable = 1'b1;
`endif

  always_comb begin
    frame_hit = (bus.digit_sel == LAST) ||
                ((state == COLLECT) && (bus.digit_sel == expected));
    write_en  = bus.seg_strobe && stable && (state != HOLD) && frame_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      expected <= '0;
      valid    <= 1'b0;
      derr     <= 1'b0;
      ovr      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) slot[i] <= 8'h00;
    end else begin
      if (write_en) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (bus.digit_sel == 3'(i)) slot[i] <= decoded[7:0];
        end
        if (decoded[8]) derr <= 1'b1;
      end
      if (bus.seg_strobe && !stable && (state != HOLD)) derr <= 1'b1;

      case (state)
        IDLE, COLLECT: begin
          if (bus.seg_strobe && stable) begin
            if (frame_hit) begin
              if (bus.digit_sel == 3'd0) begin
                state <= HOLD;
                valid <= 1'b1;
              end else begin
                expected <= bus.digit_sel - 3'd1;
                state    <= COLLECT;
              end
            end else if (state == COLLECT) begin
              // Out-of-order index abandons the frame; slot contents stay stale.
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (bus.seg_strobe) ovr <= 1'b1;
          if (bus.msg_ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
    assign bus.msg_out[8*g +: 8] = slot[g];
  end

  assign bus.msg_valid  = valid;
  assign bus.decode_err = derr;
  assign bus.overrun    = ovr;

endmodule

`default_nettype wire

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed and randomized checks of seg7_frame_decoder
// against a table-driven reference model.
`default_nettype none

module tb_seg7_frame_decoder;

  localparam int N       = 5;
  localparam bit ACT_LOW = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg7_frame_decoder_if #(.NUM_DIGITS(N)) bus ();

  seg7_frame_decoder #(
    .NUM_DIGITS    (N),
    .SEG_ACTIVE_LOW(ACT_LOW),
    .STABLE_CYCLES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference glyph table: pattern pat_tab[i] shows character glyphs[i].
  logic [6:0] pat_tab [23] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                               7'h76, 7'h1E, 7'h38, 7'h5C, 7'h73, 7'h3E, 7'h00};
  string glyphs = "0123456789AbCdEFHJLoPU ";

  // Reference model state: chars collected so far in the current frame.
  logic [7:0] m_slot [N];
  int         m_count;
  bit         m_hold, m_derr, m_ovr;

  function automatic logic [8:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 23; i++) if (pat_tab[i] == p) return {1'b0, 8'(glyphs[i])};
    return {1'b1, 8'h3F};
  endfunction

  function automatic logic [8*N-1:0] model_msg();
    logic [8*N-1:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = m_slot[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = 8'h00;
    m_count = 0; m_hold = 0; m_derr = 0; m_ovr = 0;
  endtask

  task automatic model_write(input int idx, input logic [6:0] p);
    logic [8:0] d;
    d = ref_decode(p);
    m_slot[idx] = d[7:0];
    if (d[8]) m_derr = 1;
  endtask

  task automatic model_step(input bit stb, input int idx, input logic [6:0] p, input bit rdy);
    if (m_hold) begin
      if (stb) m_ovr = 1;
      if (rdy) begin m_hold = 0; m_count = 0; end
    end else if (stb) begin
      if (idx == N - 1) begin
        model_write(idx, p); m_count = 1;
      end else if (m_count > 0 && idx == N - 1 - m_count) begin
        model_write(idx, p); m_count++;
      end else begin
        m_count = 0;
      end
      if (m_count == N) m_hold = 1;
    end
  endtask

  task automatic drive(input bit stb, input int idx, input logic [6:0] p, input bit rdy);
    bus.seg_in     = ACT_LOW ? ~p : p;
    bus.digit_sel  = 3'(idx);
    bus.seg_strobe = stb;
    bus.msg_ready  = rdy;
    @(posedge clk); #1;
    bus.seg_strobe = 1'b0;
    bus.msg_ready  = 1'b0;
  endtask

  task automatic send_char(input int idx, input logic [6:0] p);
    drive(1'b0, idx, p, 1'b0);
    drive(1'b1, idx, p, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 7'h00, 1'b0);
    drive(1'b0, 0, 7'h00, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.msg_valid, bus.decode_err, bus.overrun} !== 3'b000 || bus.msg_out !== '0) begin
      errors++;
      $display("FAIL reset: got valid/err/ovr=%b msg=%h expected 000 / 0", 
               {bus.msg_valid, bus.decode_err, bus.overrun}, bus.msg_out);
    end
  endtask

  task automatic test_hello();
    logic [6:0] p [5] = '{7'h76, 7'h79, 7'h38, 7'h38, 7'h5C};
    do_reset();
    for (int i = 0; i < 4; i++) send_char(4 - i, p[i]);
    drive(1'b0, 0, p[4], 1'b0);
    checks++;
    if (bus.msg_valid !== 1'b0) begin
      errors++; $display("FAIL hello_pre_valid: got %b expected 0", bus.msg_valid);
    end
    drive(1'b1, 0, p[4], 1'b0);
    checks++;
    if (bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL hello_valid: got %b expected 1", bus.msg_valid);
    end
    checks++;
    if (bus.msg_out !== 40'h48454C4C6F) begin
      errors++; $display("FAIL hello_msg: got %h expected 48454c4c6f", bus.msg_out);
    end
    checks++;
    if (bus.decode_err !== 1'b0) begin
      errors++; $display("FAIL hello_err: got %b expected 0", bus.decode_err);
    end
  endtask

  task automatic test_digits_handshake();
    logic [6:0] p [5] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};
    do_reset();
    for (int i = 0; i < 5; i++) send_char(4 - i, p[i]);
    checks++;
    if (bus.msg_out !== 40'h3031323334 || bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL digits_msg: got %h v=%b expected 3031323334 v=1", bus.msg_out, bus.msg_valid);
    end
    drive(1'b0, 0, 7'h00, 1'b1);
    checks++;
    if (bus.msg_valid !== 1'b0) begin
      errors++; $display("FAIL handshake_clear: got %b expected 0", bus.msg_valid);
    end
    // Back in IDLE: a lone index-0 strobe must not complete a frame.
    send_char(0, 7'h3F);
    checks++;
    if (bus.msg_valid !== 1'b0) begin
      errors++; $display("FAIL handshake_idle: got %b expected 0", bus.msg_valid);
    end
  endtask

  task automatic test_decode_err();
    logic [6:0] p [5] = '{7'h3F, 7'h06, 7'h49, 7'h4F, 7'h66};
    do_reset();
    for (int i = 0; i < 5; i++) send_char(4 - i, p[i]);
    checks++;
    if (bus.msg_out[23:16] !== 8'h3F || bus.decode_err !== 1'b1) begin
      errors++; $display("FAIL bad_pattern: got char2=%h err=%b expected 3f 1", bus.msg_out[23:16], bus.decode_err);
    end
    drive(1'b0, 0, 7'h00, 1'b1);
    drive(1'b0, 0, 7'h00, 1'b0);
    checks++;
    if (bus.decode_err !== 1'b1 || bus.msg_valid !== 1'b0) begin
      errors++; $display("FAIL err_sticky: got err=%b v=%b expected 1 0", bus.decode_err, bus.msg_valid);
    end
  endtask

  task automatic test_out_of_order();
    logic [6:0] p [5] = '{7'h1E, 7'h39, 7'h3F, 7'h3F, 7'h06};
    do_reset();
    send_char(4, 7'h3F);
    send_char(3, 7'h06);
    send_char(1, 7'h5B);
    send_char(0, 7'h4F);
    checks++;
    if (bus.msg_valid !== 1'b0) begin
      errors++; $display("FAIL out_of_order: got valid %b expected 0", bus.msg_valid);
    end
    for (int i = 0; i < 5; i++) send_char(4 - i, p[i]);
    checks++;
    if (bus.msg_out !== 40'h4A43303031 || bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL refill_msg: got %h v=%b expected 4a43303031 v=1", bus.msg_out, bus.msg_valid);
    end
  endtask

  task automatic test_overrun_and_reset();
    logic [6:0] p [5] = '{7'h76, 7'h79, 7'h38, 7'h38, 7'h5C};
    do_reset();
    for (int i = 0; i < 5; i++) send_char(4 - i, p[i]);
    send_char(4, 7'h3F);
    checks++;
    if (bus.overrun !== 1'b1 || bus.msg_out !== 40'h48454C4C6F || bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL overrun: got ovr=%b msg=%h v=%b expected 1 48454c4c6f 1",
                         bus.overrun, bus.msg_out, bus.msg_valid);
    end
    drive(1'b0, 0, 7'h00, 1'b1);
    send_char(4, 7'h3F);
    send_char(3, 7'h06);
    rst = 1'b1;
    drive(1'b0, 0, 7'h00, 1'b0);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({bus.msg_valid, bus.decode_err, bus.overrun} !== 3'b000 || bus.msg_out !== '0) begin
      errors++; $display("FAIL mid_reset: got flags=%b msg=%h expected 000 0",
                         {bus.msg_valid, bus.decode_err, bus.overrun}, bus.msg_out);
    end
    // Index 2 right after reset must not be taken as a frame continuation.
    send_char(2, 7'h5B);
    for (int i = 0; i < 5; i++) send_char(4 - i, pat_tab[i]);
    checks++;
    if (bus.msg_out !== 40'h3031323334 || bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_frame: got %h v=%b expected 3031323334 v=1", bus.msg_out, bus.msg_valid);
    end
  endtask

`ifdef SEG7_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [6:0] p [5] = '{7'h76, 7'h79, 7'h38, 7'h38, 7'h5C};
    do_reset();
    drive(1'b0, 4, 7'h3F, 1'b0);
    drive(1'b1, 4, 7'h06, 1'b0);
    checks++;
    if (bus.decode_err !== 1'b1 || bus.msg_out[39:32] !== 8'h00) begin
      errors++; $display("FAIL glitch_reject: got err=%b c4=%h expected 1 00", bus.decode_err, bus.msg_out[39:32]);
    end
    for (int i = 0; i < 5; i++) send_char(4 - i, p[i]);
    checks++;
    if (bus.msg_out !== 40'h48454C4C6F || bus.msg_valid !== 1'b1) begin
      errors++; $display("FAIL glitch_accept: got %h v=%b expected 48454c4c6f 1", bus.msg_out, bus.msg_valid);
    end
  endtask
`endif

  task automatic test_random();
    bit         stb, rdy;
    int         idx;
    logic [6:0] p;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      stb = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 75)
        idx = (m_count > 0 && m_count < N) ? N - 1 - m_count : N - 1;
      else
        idx = $urandom_range(0, 7);
      p   = ($urandom_range(0, 99) < 90) ? pat_tab[$urandom_range(0, 22)] : 7'($urandom_range(0, 127));
      rdy = ($urandom_range(0, 99) < 30);
      model_step(stb, idx, p, rdy);
      drive(stb, idx, p, rdy);
      checks++;
      if (bus.msg_valid !== m_hold || bus.decode_err !== m_derr || bus.overrun !== m_ovr) begin
        errors++; $display("FAIL rand_flags cyc %0d: got v/e/o=%b%b%b expected %b%b%b", c,
                           bus.msg_valid, bus.decode_err, bus.overrun, m_hold, m_derr, m_ovr);
      end
      checks++;
      if (bus.msg_out !== model_msg()) begin
        errors++; $display("FAIL rand_msg cyc %0d: got %h expected %h", c, bus.msg_out, model_msg());
      end
    end
  endtask

  initial begin
    bus.seg_in     = '0;
    bus.digit_sel  = '0;
    bus.seg_strobe = 1'b0;
    bus.msg_ready  = 1'b0;
    model_reset();
    test_reset();
    test_hello();
    test_digits_handshake();
    test_decode_err();
    test_out_of_order();
    test_overrun_and_reset();
`ifdef SEG7_GLITCH_FILTER_EN
    test_glitch();
`else
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Receive-side counterpart of the team's ASCII-to-seven-segment display path.
- Samples time-multiplexed seven-segment patterns (segment lines plus digit index plus strobe) and decodes each pattern back to an 8-bit ASCII code.
- Assembles NUM_DIGITS characters into a message frame and presents it with a valid/ready handshake.
- Used to loop back display traffic for self-check, and to read display traffic from a peer board.

Parameters:
- NUM_DIGITS, 5: characters per frame. Digit index NUM_DIGITS-1 is the leftmost character.
- SEG_ACTIVE_LOW, 1: when 1, SegIn is inverted before decode (active-low board segments).
- STABLE_CYCLES, 2: hold-off length used only by the optional glitch filter.

Ports:
- Clk  in  1  single system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- SegIn  in  7  segment pattern, bit order gfedcba.
- DigitSel  in  3  index of the digit SegIn belongs to.
- SegStrobe  in  1  one-cycle qualifier; SegIn and DigitSel are sampled when it is high.
- MsgOut  out  8*NUM_DIGITS  decoded frame; char[i] = MsgOut[8i+7:8i].
- MsgValid  out  1  frame available.
- MsgReady  in  1  consumer accepts the frame when MsgValid && MsgReady.
- DecodeErr  out  1  sticky; set by an unknown pattern.
- Overrun  out  1  sticky; set by a strobe dropped while in HOLD.

Behaviour:
- Reset state: all outputs 0, MsgOut all 0x00, FSM = IDLE, slot-filled mask cleared. Reset mid-frame discards the partial frame.
- Decode is performed on the active-high pattern p (SegIn inverted when SEG_ACTIVE_LOW=1). Table, p -> ASCII:
  - 3F->'0', 06->'1', 5B->'2', 4F->'3', 66->'4', 6D->'5', 7D->'6', 07->'7', 7F->'8', 6F->'9'
  - 77->'A', 7C->'b', 39->'C', 5E->'d', 79->'E', 71->'F', 76->'H', 1E->'J', 38->'L', 5C->'o', 73->'P', 3E->'U'
  - 00->' ' (0x20)
  - Any other pattern -> '?' (0x3F), and DecodeErr is set.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - Strobe with DigitSel==NUM_DIGITS-1: write the slot, set expected index = NUM_DIGITS-2, go to COLLECT.
  - Any other strobe is ignored.
- COLLECT:
  - Strobe with DigitSel==expected: write the slot and decrement expected.
  - When slot 0 is written, go to HOLD. MsgValid rises the cycle after that strobe (latency 1 clock from strobe to valid).
  - Strobe with DigitSel==NUM_DIGITS-1: restart the frame (treated as in IDLE).
  - Strobe with any other index (out of order, or >= NUM_DIGITS): discard the frame, go to IDLE. Slots keep their stale data, but MsgValid stays 0.
- HOLD:
  - MsgValid=1 and MsgOut stable.
  - MsgValid && MsgReady: clear MsgValid the next cycle, go to IDLE.
  - Same-cycle strobe on the handshake cycle: dropped, Overrun set.
  - Any strobe while in HOLD: dropped, Overrun set.
- Slot writes: each slot is written only on its own accepted strobe; other slots are unchanged.
- Sticky flags: DecodeErr and Overrun clear only on Reset.
- DigitSel values >= NUM_DIGITS are never written to a slot.

Optional Feature:
- Macro: SEG7_GLITCH_FILTER_EN.
- Defined:
  - A strobe is accepted only if SegIn is unchanged for STABLE_CYCLES consecutive clocks ending at the strobe cycle.
  - Otherwise the strobe is ignored, DecodeErr is set, and FSM state is unchanged.
- Not defined: every strobe is accepted with no history check; STABLE_CYCLES is unused.

Test Plan:
- Strobes (SEG_ACTIVE_LOW=0), indices 4..0 with patterns 76,79,38,38,5C, MsgReady=0 -> MsgValid=1 the cycle after the index-0 strobe; MsgOut = "HELLo" (0x48,0x45,0x4C,0x4C,0x6F, char[4] first); DecodeErr=0.
- Active-low: SegIn ~(3F,06,5B,4F,66) on indices 4..0 -> MsgOut "01234"; then MsgReady=1 for one cycle -> MsgValid=0 the next cycle, FSM IDLE.
- Pattern 0x49 at index 2 within an otherwise valid frame -> char[2]=0x3F, DecodeErr=1 and stays 1 after the handshake.
- Indices 4,3,1 -> no MsgValid; the next frame 4..0 of "1E,39,3F,3F,06" -> MsgOut "JC001".
- A strobe while in HOLD -> MsgOut unchanged, Overrun=1. Reset asserted mid-COLLECT -> all outputs 0 next cycle, and the next full frame decodes correctly.
- With SEG7_GLITCH_FILTER_EN and STABLE_CYCLES=2: SegIn changes on the strobe cycle -> strobe ignored, DecodeErr=1. SegIn held 2 cycles -> accepted.
